// File: rtl/seg7_scan_driver_if.sv
// Bundle between the time-keeping logic and the four-digit seven-segment scan driver.
// master: clock/time-set side that supplies digits and strobes; slave: the scan driver.
interface seg7_scan_driver_if;
    logic       scan_tick;
    logic [2:0] minutes_tens;
    logic [3:0] minutes_ones;
    logic [2:0] seconds_tens;
    logic [3:0] seconds_ones;
    logic       set_active;
    logic [1:0] set_digit;
    logic [3:0] an_n;
    logic [6:0] seg_n;
    logic       dp_n;

    modport master (
        output scan_tick, minutes_tens, minutes_ones, seconds_tens, seconds_ones,
        output set_active, set_digit,
        input  an_n, seg_n, dp_n
    );

    modport slave (
        input  scan_tick, minutes_tens, minutes_ones, seconds_tens, seconds_ones,
        input  set_active, set_digit,
        output an_n, seg_n, dp_n
    );
endinterface

// File: rtl/seg7_scan_driver.sv
// Four-digit multiplexed seven-segment driver with frame-coherent digit shadowing.
// Optional edit-digit blinking is compiled in when SEG7_BLINK_EN is defined.
module seg7_scan_driver #(
    parameter int BLINK_TICKS = 200
) (
    input  logic                clk,
    input  logic                rst_n,
    seg7_scan_driver_if.slave   bus
);

    typedef logic [3:0] digit_t;

    // Active-low {g,f,e,d,c,b,a}; anything above 9 renders as a dash.
    function automatic logic [6:0] encode(input digit_t d);
        case (d)
            4'd0:    encode = 7'b1000000;
            4'd1:    encode = 7'b1111001;
            4'd2:    encode = 7'b0100100;
            4'd3:    encode = 7'b0110000;
            4'd4:    encode = 7'b0011001;
            4'd5:    encode = 7'b0010010;
            4'd6:    encode = 7'b0000010;
            4'd7:    encode = 7'b1111000;
            4'd8:    encode = 7'b0000000;
            4'd9:    encode = 7'b0010000;
            default: encode = 7'b0111111;
        endcase
    endfunction

    logic [1:0]         idx;
    logic               running;
    logic [3:0][3:0]    shadow;
    logic [3:0]         an_q;
    logic [6:0]         seg_q;
    logic               dp_q;

    logic [1:0]         idx_next;
    logic [3:0][3:0]    shadow_next;
    logic [3:0]         an_next;
    logic               blank;

    // The first tick after reset shows digit 0 without advancing; later ticks advance.
    always_comb begin
        idx_next    = running ? idx + 2'd1 : idx;
        shadow_next = shadow;
        if (!running || idx == 2'd3)
            shadow_next = {{1'b0, bus.minutes_tens}, bus.minutes_ones,
                           {1'b0, bus.seconds_tens}, bus.seconds_ones};
        an_next = ~(4'b0001 << idx_next);
        if (blank)
            an_next = 4'b1111;
    end

`ifdef SEG7_BLINK_EN
    localparam int CNT_W = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

    logic               set_q;
    logic               set_rise;
    logic [CNT_W-1:0]   blink_cnt;
    logic               blink_on;

    assign set_rise = bus.set_active & ~set_q;
    // A rise forces the visible phase even if it lands on a tick.
    assign blank    = bus.set_active & ~(set_rise | blink_on) & (idx_next == bus.set_digit);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            set_q     <= 1'b0;
            blink_cnt <= '0;
            blink_on  <= 1'b1;
        end else begin
            set_q <= bus.set_active;
            if (set_rise) begin
                blink_cnt <= '0;
                blink_on  <= 1'b1;
            end else if (bus.scan_tick) begin
                if (blink_cnt == CNT_W'(BLINK_TICKS - 1)) begin
                    blink_cnt <= '0;
                    blink_on  <= ~blink_on;
                end else begin
                    blink_cnt <= blink_cnt + 1'b1;
                end
            end
        end
    end
`else
    logic unused_set;
    assign blank      = 1'b0;
    // Edit controls have no effect in this build.
    assign unused_set = &{1'b0, bus.set_active, bus.set_digit, BLINK_TICKS[0]};
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx     <= 2'd0;
            running <= 1'b0;
            // NOTE: the shadow is only four nibbles, so it is reset like any other register.
            shadow  <= '0;
            an_q    <= 4'b1111;
            seg_q   <= 7'b1111111;
            dp_q    <= 1'b1;
        end else if (bus.scan_tick) begin
            // NOTE: non-blocking so every register sees pre-edge values of its peers.
            idx     <= idx_next;
            running <= 1'b1;
            shadow  <= shadow_next;
            an_q    <= an_next;
            seg_q   <= encode(shadow_next[idx_next]);
            dp_q    <= (idx_next != 2'd2);
        end
    end

    assign bus.an_n  = an_q;
    assign bus.seg_n = seg_q;
    assign bus.dp_n  = dp_q;

endmodule
